// File: rtl/multi_uart_hub.sv
// N-channel 8N1 UART hub on one Avalon-MM slave; per-channel divisor, TX/RX FIFOs, sticky flags, shared irq.
// Optional internal loopback is built only when MULTI_UART_LOOPBACK_EN is defined.
module multi_uart_hub #(
  parameter int NUM_CH      = 4,
  parameter int CH_AW       = 2,
  parameter int FIFO_DEPTH  = 16,
  parameter int DEFAULT_DIV = 434
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CH_AW+1:0]  address,
  input  logic              chipselect,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              irq,
  input  logic [NUM_CH-1:0] uart_rxd,
  output logic [NUM_CH-1:0] uart_txd
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [15:0] DIV_RST = 16'(DEFAULT_DIV);
  localparam logic [CH_AW:0] NUM_CH_W = (CH_AW+1)'(NUM_CH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_e;

  logic [CH_AW-1:0] ch_sel;
  logic [1:0]       reg_sel;
  logic             ch_ok, wr_en, rd_en;
  logic [31:0]      rd_word [NUM_CH];
  logic [NUM_CH-1:0] irq_vec;
  logic             unused_wdata;

  assign ch_sel  = address[CH_AW+1:2];
  assign reg_sel = address[1:0];
  assign ch_ok   = ({1'b0, ch_sel} < NUM_CH_W);
  assign wr_en   = chipselect & write;
  assign rd_en   = chipselect & read;
  assign unused_wdata = ^writedata[31:16];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic        sel, wr_data, rd_data, wr_stat, wr_div, wr_ctrl;
    logic [15:0] div_q, tx_div, rx_div;
    logic        irq_en, loop_en, rx_ovr, frm_err, tx_ovf;
    logic [7:0]  tx_mem [FIFO_DEPTH];
    logic [7:0]  rx_mem [FIFO_DEPTH];
    logic [AW:0] tx_wp, tx_rp, rx_wp, rx_rp;
    logic        tx_empty, tx_full, tx_push, tx_pop;
    logic        rx_empty, rx_full, rx_push, rx_pop, rx_push_req, rx_frm;
    uart_state_e tx_st, tx_nx, rx_st, rx_nx;
    logic [15:0] tx_cnt, rx_cnt;
    logic [2:0]  tx_bit, rx_bit;
    logic [7:0]  tx_sh, rx_sh, rx_head;
    logic        tx_line, tx_tick, rx_tick;
    logic        rx_s1, rx_s2, rx_s3, rx_src, rx_fall;

    assign sel     = ch_ok && (ch_sel == CH_AW'(i));
    assign wr_data = wr_en & sel & (reg_sel == 2'd0);
    assign wr_stat = wr_en & sel & (reg_sel == 2'd1);
    assign wr_div  = wr_en & sel & (reg_sel == 2'd2);
    assign wr_ctrl = wr_en & sel & (reg_sel == 2'd3);
    assign rd_data = rd_en & sel & (reg_sel == 2'd0);

    // Extra MSB on the pointers distinguishes full from empty.
    assign tx_empty = (tx_wp == tx_rp);
    assign tx_full  = (tx_wp[AW] != tx_rp[AW]) && (tx_wp[AW-1:0] == tx_rp[AW-1:0]);
    assign rx_empty = (rx_wp == rx_rp);
    assign rx_full  = (rx_wp[AW] != rx_rp[AW]) && (rx_wp[AW-1:0] == rx_rp[AW-1:0]);
    assign tx_push  = wr_data && (!tx_full || tx_pop);
    assign rx_pop   = rd_data && !rx_empty;
    assign rx_push  = rx_push_req && (!rx_full || rx_pop);
    assign rx_head  = rx_empty ? 8'd0 : rx_mem[rx_rp[AW-1:0]];

    always_ff @(posedge clk) begin
      if (reset) begin
        tx_wp <= '0; tx_rp <= '0; rx_wp <= '0; rx_rp <= '0;
      end else begin
        if (tx_push) tx_wp <= tx_wp + 1'b1;
        if (tx_pop)  tx_rp <= tx_rp + 1'b1;
        if (rx_push) rx_wp <= rx_wp + 1'b1;
        if (rx_pop)  rx_rp <= rx_rp + 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (tx_push) tx_mem[tx_wp[AW-1:0]] <= writedata[7:0];
      if (rx_push) rx_mem[rx_wp[AW-1:0]] <= rx_sh;
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        div_q <= DIV_RST; irq_en <= 1'b0;
        rx_ovr <= 1'b0; frm_err <= 1'b0; tx_ovf <= 1'b0;
      end else begin
        if (wr_div)  div_q  <= (writedata[15:1] == 15'd0) ? 16'd2 : writedata[15:0];
        if (wr_ctrl) irq_en <= writedata[0];
        // A same-cycle error event wins over the write-1-to-clear.
        rx_ovr  <= (rx_ovr  & ~(wr_stat & writedata[4])) | (rx_push_req & ~rx_push);
        frm_err <= (frm_err & ~(wr_stat & writedata[5])) | rx_frm;
        tx_ovf  <= (tx_ovf  & ~(wr_stat & writedata[7])) | (wr_data & ~tx_push);
      end
    end

`ifdef MULTI_UART_LOOPBACK_EN
    always_ff @(posedge clk) begin
      if (reset)        loop_en <= 1'b0;
      else if (wr_ctrl) loop_en <= writedata[1];
    end
    assign rx_src      = loop_en ? tx_line : uart_rxd[i];
    assign uart_txd[i] = loop_en | tx_line;
`else
    assign loop_en     = 1'b0;
    assign rx_src      = uart_rxd[i];
    assign uart_txd[i] = tx_line;
`endif

    // TX FSM
    assign tx_tick = (tx_cnt == tx_div - 16'd1);
    always_ff @(posedge clk) begin
      if (reset) tx_st <= S_IDLE;
      else       tx_st <= tx_nx;
    end
    always_comb begin
      tx_nx   = tx_st;
      tx_pop  = 1'b0;
      tx_line = 1'b1;
      case (tx_st)
        S_IDLE:  if (!tx_empty) begin tx_nx = S_START; tx_pop = 1'b1; end
        S_START: begin tx_line = 1'b0; if (tx_tick) tx_nx = S_DATA; end
        S_DATA:  begin tx_line = tx_sh[0]; if (tx_tick && tx_bit == 3'd7) tx_nx = S_STOP; end
        S_STOP:  if (tx_tick) begin
                   if (!tx_empty) begin tx_nx = S_START; tx_pop = 1'b1; end
                   else tx_nx = S_IDLE;
                 end
        default: tx_nx = S_IDLE;
      endcase
    end
    always_ff @(posedge clk) begin
      if (reset) begin
        tx_cnt <= '0; tx_bit <= '0; tx_sh <= '0; tx_div <= DIV_RST;
      end else if (tx_pop) begin
        tx_cnt <= '0; tx_bit <= '0;
        tx_sh  <= tx_mem[tx_rp[AW-1:0]];
        tx_div <= div_q;
      end else if (tx_st != S_IDLE) begin
        if (tx_tick) begin
          tx_cnt <= '0;
          if (tx_st == S_DATA) begin tx_sh <= {1'b0, tx_sh[7:1]}; tx_bit <= tx_bit + 1'b1; end
        end else tx_cnt <= tx_cnt + 16'd1;
      end
    end

    // RX FSM; rx_s3 is the previous synchronised level for edge detection.
    always_ff @(posedge clk) begin
      if (reset) begin rx_s1 <= 1'b1; rx_s2 <= 1'b1; rx_s3 <= 1'b1; end
      else       begin rx_s1 <= rx_src; rx_s2 <= rx_s1; rx_s3 <= rx_s2; end
    end
    assign rx_fall = rx_s3 & ~rx_s2;
    assign rx_tick = (rx_st == S_START) ? (rx_cnt == (rx_div >> 1) - 16'd1)
                                        : (rx_cnt == rx_div - 16'd1);
    always_ff @(posedge clk) begin
      if (reset) rx_st <= S_IDLE;
      else       rx_st <= rx_nx;
    end
    always_comb begin
      rx_nx       = rx_st;
      rx_push_req = 1'b0;
      rx_frm      = 1'b0;
      case (rx_st)
        S_IDLE:  if (rx_fall) rx_nx = S_START;
        S_START: if (rx_tick) rx_nx = rx_s2 ? S_IDLE : S_DATA;
        S_DATA:  if (rx_tick && rx_bit == 3'd7) rx_nx = S_STOP;
        S_STOP:  if (rx_tick) begin rx_nx = S_IDLE; rx_push_req = rx_s2; rx_frm = ~rx_s2; end
        default: rx_nx = S_IDLE;
      endcase
    end
    always_ff @(posedge clk) begin
      if (reset) begin
        rx_cnt <= '0; rx_bit <= '0; rx_sh <= '0; rx_div <= DIV_RST;
      end else if (rx_st == S_IDLE) begin
        rx_cnt <= '0; rx_bit <= '0;
        if (rx_fall) rx_div <= div_q;
      end else if (rx_tick) begin
        rx_cnt <= '0;
        if (rx_st == S_DATA) begin rx_sh <= {rx_s2, rx_sh[7:1]}; rx_bit <= rx_bit + 1'b1; end
      end else rx_cnt <= rx_cnt + 16'd1;
    end

    assign rd_word[i] =
      (reg_sel == 2'd0) ? {23'd0, ~rx_empty, rx_head} :
      (reg_sel == 2'd1) ? {24'd0, tx_ovf, (tx_st != S_IDLE), frm_err, rx_ovr,
                           tx_full, tx_empty, rx_full, rx_empty} :
      (reg_sel == 2'd2) ? {16'd0, div_q} :
                          {30'd0, loop_en, irq_en};
    assign irq_vec[i] = irq_en & ~rx_empty;
  end

  always_ff @(posedge clk) begin
    if (reset)      readdata <= 32'd0;
    else if (rd_en) readdata <= ch_ok ? rd_word[ch_sel] : 32'd0;
  end

  assign irq = |irq_vec;
endmodule

// File: tb/tb_multi_uart_hub.sv
// Self-checking bench for multi_uart_hub: reads are scoreboarded, serial lines and irq checked directly.
module tb_multi_uart_hub;
  localparam int NUM_CH = 4;
  localparam int CH_AW  = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [CH_AW+1:0]  address;
  logic              chipselect, read, write;
  logic [31:0]       writedata;
  logic [31:0]       readdata;
  logic              irq;
  logic [NUM_CH-1:0] uart_rxd;
  logic [NUM_CH-1:0] uart_txd;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  string       name_q[$];
  logic        rd_vld = 1'b0;

  multi_uart_hub #(.NUM_CH(NUM_CH), .CH_AW(CH_AW), .FIFO_DEPTH(16), .DEFAULT_DIV(434)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .read(read), .write(write), .writedata(writedata), .readdata(readdata),
    .irq(irq), .uart_rxd(uart_rxd), .uart_txd(uart_txd)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic bus_write(input int ch, input int rg, input logic [31:0] data);
    logic [31:0] c;
    c = ch;
    @(negedge clk);
    address = {c[CH_AW-1:0], 2'(rg)}; writedata = data;
    chipselect = 1'b1; write = 1'b1;
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic bus_read(input int ch, input int rg, input logic [31:0] exp, input string name);
    logic [31:0] c;
    c = ch;
    @(negedge clk);
    address = {c[CH_AW-1:0], 2'(rg)};
    chipselect = 1'b1; read = 1'b1;
    exp_q.push_back(exp); name_q.push_back(name);
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0;
  endtask

  task automatic uart_send(input int ch, input logic [7:0] b, input int div, input logic stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      uart_rxd[ch] = fr[k];
      repeat (div) @(negedge clk);
    end
    uart_rxd[ch] = 1'b1;
  endtask

  // Scoreboard monitor: readdata is valid the cycle after the read strobe.
  always @(posedge clk) rd_vld <= chipselect & read;
  always @(negedge clk) begin
    if (rd_vld) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_read actual=0x%0h expected=none", readdata);
      end else begin
        check(name_q.pop_front(), readdata, exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [9:0]  bits;
    logic [31:0] bad;
    reset = 1'b0; address = '0; chipselect = 1'b0; read = 1'b0; write = 1'b0;
    writedata = '0; uart_rxd = '1;
    do_reset();

    check("rst_readdata", readdata, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_txd", {28'd0, uart_txd}, 32'hF);
    bus_read(0, 1, 32'h05, "rst_status");
    bus_read(0, 2, 32'd434, "rst_divisor");
    bus_read(0, 3, 32'h0, "rst_control");
    bus_read(0, 0, 32'h0, "rst_data_empty");

    // TX frame 0x5A at div 4
    bus_write(0, 2, 32'd4);
    bus_read(0, 2, 32'd4, "div_readback");
    bus_write(0, 0, 32'h5A);
    check("tx_idle_before_start", {31'd0, uart_txd[0]}, 32'd1);
    bits = {1'b1, 8'h5A, 1'b0};
    bad = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (uart_txd[0] !== bits[c/4]) begin
        bad++;
        $display("FAIL tx_bit cycle=%0d actual=%0b expected=%0b", c, uart_txd[0], bits[c/4]);
      end
    end
    check("tx_frame_bad_cycles", bad, 32'd0);
    check("tx_line_after_frame", {31'd0, uart_txd[0]}, 32'd1);
    bus_read(0, 1, 32'h05, "tx_done_status");

    // RX single byte on ch2 at div 8
    bus_write(2, 2, 32'd8);
    uart_send(2, 8'hC3, 8, 1'b1);
    repeat (4) @(negedge clk);
    bus_read(2, 1, 32'h04, "rx_status_nonempty");
    bus_read(2, 0, 32'h1C3, "rx_data_c3");
    bus_read(2, 0, 32'h000, "rx_data_empty");

    // RX overrun: FIFO_DEPTH+1 bytes
    for (int n = 0; n < 17; n++) uart_send(2, 8'(8'h10 + n), 8, 1'b1);
    repeat (4) @(negedge clk);
    bus_read(2, 1, 32'h16, "rx_full_overrun");
    bus_write(2, 1, 32'h10);
    bus_read(2, 1, 32'h06, "rx_overrun_cleared");
    for (int n = 0; n < 16; n++) bus_read(2, 0, 32'h100 | (32'h10 + n), "rx_fifo_order");
    bus_read(2, 1, 32'h05, "rx_drained_status");

    // Framing error, then a short glitch
    uart_send(2, 8'h55, 8, 1'b0);
    repeat (6) @(negedge clk);
    bus_read(2, 1, 32'h25, "framing_err_set");
    bus_read(2, 0, 32'h0, "framing_no_push");
    bus_write(2, 1, 32'h20);
    bus_read(2, 1, 32'h05, "framing_cleared");
    @(negedge clk); uart_rxd[2] = 1'b0;
    repeat (2) @(negedge clk); uart_rxd[2] = 1'b1;
    repeat (20) @(negedge clk);
    bus_read(2, 1, 32'h05, "glitch_no_flags");
    bus_read(2, 0, 32'h0, "glitch_no_push");
    uart_send(2, 8'h81, 8, 1'b1);
    repeat (4) @(negedge clk);
    bus_read(2, 0, 32'h181, "rx_after_glitch");

    // irq on ch1 only
    bus_write(1, 2, 32'd8);
    bus_write(3, 2, 32'd8);
    bus_write(1, 3, 32'h1);
    check("irq_idle", {31'd0, irq}, 32'd0);
    uart_send(3, 8'h33, 8, 1'b1);
    repeat (4) @(negedge clk);
    check("irq_ch3_masked", {31'd0, irq}, 32'd0);
    uart_send(1, 8'h11, 8, 1'b1);
    repeat (4) @(negedge clk);
    check("irq_ch1_set", {31'd0, irq}, 32'd1);
    bus_read(3, 0, 32'h133, "ch3_data");
    check("irq_after_ch3_read", {31'd0, irq}, 32'd1);
    bus_read(1, 0, 32'h111, "ch1_data");
    check("irq_after_ch1_drain", {31'd0, irq}, 32'd0);

    // Divisor clamp
    bus_write(3, 2, 32'd1);
    bus_read(3, 2, 32'd2, "div_clamp_1");
    bus_write(3, 2, 32'd0);
    bus_read(3, 2, 32'd2, "div_clamp_0");

    // TX overflow and reset mid-frame
    bus_write(0, 2, 32'd1000);
    for (int n = 0; n < 18; n++) bus_write(0, 0, 32'(n));
    bus_read(0, 1, 32'hC9, "tx_full_ovf");
    bus_write(0, 1, 32'h80);
    bus_read(0, 1, 32'h49, "tx_ovf_cleared");
    check("tx_in_start_bit", {31'd0, uart_txd[0]}, 32'd0);
    do_reset();
    check("reset_midframe_txd", {31'd0, uart_txd[0]}, 32'd1);
    bus_read(0, 1, 32'h05, "reset_midframe_status");

`ifdef MULTI_UART_LOOPBACK_EN
    bus_write(0, 2, 32'd4);
    bus_write(0, 3, 32'h2);
    bus_read(0, 3, 32'h2, "loop_control");
    bus_write(0, 0, 32'hA5);
    bad = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (uart_txd[0] !== 1'b1) bad++;
    end
    check("loop_txd_high", bad, 32'd0);
    bus_read(0, 0, 32'h1A5, "loop_data");
`else
    bus_write(0, 3, 32'h3);
    bus_read(0, 3, 32'h1, "control_no_loopback");
`endif

    repeat (4) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
